// File: rtl/adc_ch_merge.sv
// adc_ch_merge: eight one-deep sample holders merged onto a one-hot flag / 16-bit data bus by a round-robin arbiter.
// Build option ADC_CH_TAG_EN: tag bits [15:12] with the channel index; otherwise the sample is sign-extended.
module adc_ch_merge #(
    parameter int NCH = 8,
    parameter int DW  = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NCH-1:0]    ChannelEn,
    input  logic [NCH-1:0]    adc_in_valid,
    input  logic [NCH*DW-1:0] adc_in_data,
    input  logic              ClearOvr,
    output logic [NCH-1:0]    adc_data_flag,
    output logic [15:0]       adc_data_mult_ch,
    output logic [NCH-1:0]    overrun
);
    localparam int IW = $clog2(NCH);

    logic [DW-1:0]  hold_q [NCH];
    logic [DW-1:0]  hold_d [NCH];
    logic [NCH-1:0] pend_q, pend_d;
    logic [IW-1:0]  last_q, last_d;
    logic [NCH-1:0] flag_q, flag_d;
    logic [15:0]    data_q, data_d;
    logic [NCH-1:0] ovr_q, ovr_d;

    logic [NCH-1:0] cap;
    logic           grant_vld;
    logic [IW-1:0]  grant_idx;
    logic [IW-1:0]  probe;
    logic [DW-1:0]  grant_sample;
    logic [15:0]    grant_word;

    assign cap = adc_in_valid & ChannelEn;

    // Rotating search from last+1; the final probe (i == NCH) revisits the last grant itself.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        probe     = '0;
        for (int i = 1; i <= NCH; i++) begin
            probe = last_q + IW'(i);
            if (!grant_vld && pend_q[probe]) begin
                grant_vld = 1'b1;
                grant_idx = probe;
            end
        end
    end

    assign grant_sample = hold_q[grant_idx];

`ifdef ADC_CH_TAG_EN
    assign grant_word = {1'b0, grant_idx, grant_sample};
`else
    assign grant_word = {{(16-DW){grant_sample[DW-1]}}, grant_sample};
`endif

    // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
    always_comb begin
        flag_d = '0;
        data_d = data_q;
        last_d = last_q;
        pend_d = pend_q;
        hold_d = hold_q;
        ovr_d  = ClearOvr ? '0 : ovr_q;
        if (grant_vld) begin
            flag_d[grant_idx] = 1'b1;
            data_d            = grant_word;
            last_d            = grant_idx;
            pend_d[grant_idx] = 1'b0;
        end
        // A capture on the channel being granted refills it; only an ungranted pending slot overruns.
        for (int k = 0; k < NCH; k++) begin
            if (cap[k]) begin
                hold_d[k] = adc_in_data[k*DW +: DW];
                pend_d[k] = 1'b1;
                if (pend_q[k] && !(grant_vld && grant_idx == IW'(k))) begin
                    ovr_d[k] = 1'b1;
                end
            end
        end
    end

    // NOTE: holding registers are reset along with the flags, so a discarded sample can never resurface.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < NCH; k++) begin
                hold_q[k] <= '0;
            end
            pend_q <= '0;
            last_q <= IW'(NCH - 1);
            flag_q <= '0;
            data_q <= '0;
            ovr_q  <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling the pre-edge state.
            hold_q <= hold_d;
            pend_q <= pend_d;
            last_q <= last_d;
            flag_q <= flag_d;
            data_q <= data_d;
            ovr_q  <= ovr_d;
        end
    end

    assign adc_data_flag    = flag_q;
    assign adc_data_mult_ch = data_q;
    assign overrun          = ovr_q;
endmodule

// File: doc/adc_ch_merge.md
# adc_ch_merge

Merges eight independent AD9226 sample streams into the single time-multiplexed bus that feeds the ADC FIFO write controller. Each channel's 12-bit sample is captured into a one-deep holding register. A round-robin arbiter then emits at most one sample per clock as a one-hot channel flag plus a 16-bit data word. This is the stage directly upstream of the FIFO write controller: its `adc_data_flag` / `adc_data_mult_ch` outputs connect straight to that block's inputs of the same names.

## Interface
Parameters:
- `NCH`, 8 — number of channels; fixed at 8 to match the 8-bit flag bus.
- `DW`, 12 — ADC sample width.

Ports:
- `Clk`  in  1  system clock; all inputs are synchronous to it.
- `Reset`  in  1  asynchronous, active-high reset.
- `ChannelEn`  in  8  per-channel enable; strobes on disabled channels are ignored.
- `adc_in_valid`  in  8  per-channel single-cycle sample strobe.
- `adc_in_data`  in  96  packed samples; channel k occupies bits [12k+11:12k].
- `ClearOvr`  in  1  single-cycle pulse that clears all overrun flags.
- `adc_data_flag`  out  8  one-hot flag for the channel being emitted this cycle; all-zero when idle.
- `adc_data_mult_ch`  out  16  sample word, valid in the same cycle as the flag.
- `overrun`  out  8  sticky per-channel overrun flags.

## Operation
- Per-channel state: `hold[k]` (12 bits) and `pend[k]` (1 bit).
- Capture: when `adc_in_valid[k] && ChannelEn[k]`, load `hold[k]` from the input and set `pend[k]`.
- Arbitration:
  - Register `last` (3 bits) holds the most recently granted channel; its reset value is 7, so channel 0 has first priority after reset.
  - Each cycle the arbiter grants the first pending channel found searching `last+1, last+2, …` modulo 8.
  - On a grant: the flag bit is set, the data word is emitted, `pend[g]` is cleared, and `last` becomes g.
  - No grant occurs when no channel is pending. Each channel is searched exactly once per cycle.
- Data format, with CH_TAG_EN defined: {1'b0, ch[2:0], hold[11:0]}.
- Simultaneous capture and grant on the same channel:
  - The old `hold` value is emitted.
  - The new sample is stored and `pend` remains 1.
  - This is not an overrun.
- Overrun: a capture on channel k while `pend[k]`=1 and k is not granted that cycle sets `overrun[k]`. The new sample overwrites `hold[k]` (the newest sample wins).
- `ClearOvr` clears all `overrun` bits. A new overrun event in the same cycle as `ClearOvr` wins (the bit stays 1).
- Deasserting `ChannelEn[k]` blocks new captures only. An already-pending sample is still emitted.
- Reset asserted mid-operation: all state clears immediately and any pending samples are discarded.

## Timing
- Reset values:
  - `adc_data_flag`=0, `adc_data_mult_ch`=0, `overrun`=0.
  - All `pend`=0, all `hold`=0, `last`=7.
- Outputs are registered. Flag and data change on the same edge.
- Latency: input strobe at edge N → `hold`/`pend` updated at N+1 → flag and data asserted after edge N+2, for one cycle, when uncontested. The fixed latency is 2 cycles.
- When the flag is all-zero, `adc_data_mult_ch` holds its last emitted value.
- Throughput is at most one sample per cycle.
- Zero overruns are guaranteed if each channel strobes at most once every 8 cycles.
- Worst-case wait for a pending channel is 7 cycles after its own capture.
- `overrun[k]` rises one cycle after the offending strobe edge.

## Configuration
- `ADC_CH_TAG_EN` defined: bits [15:12] = {1'b0, channel index}, bits [11:0] = raw sample.
- `ADC_CH_TAG_EN` undefined: bits [15:0] = sample sign-extended from bit 11 (two's-complement interpretation).
- Flag behaviour is identical in both builds.

## Test plan
- After reset, single strobe on ch3 with data 0xABC, tag enabled → two cycles later: flag=0x08 and data=0x3ABC for one cycle; overrun=0.
- All eight channels strobe in the same cycle with data 0x100+k → flags emitted 0x01,0x02,…,0x80 on 8 consecutive cycles with matching data; no overrun.
- Ch5 strobes twice, two cycles apart, while ch0–ch4 are kept pending → overrun[5]=1. The emitted ch5 value is the second sample. A `ClearOvr` pulse → overrun=0.
- Ch2 strobes in the exact cycle ch2 is granted → the old value is emitted; the new value is emitted on ch2's next grant; overrun[2] stays 0.
- `ChannelEn`=0xFE with strobes on all channels → no ch0 flag ever appears. Tag disabled, ch1 data 0x800 → data=0xF800.
- Reset pulsed while 4 channels are pending → outputs go to 0 asynchronously. After release, no flags appear until new strobes arrive.
